// File: rtl/pixel_depth_writer_if.sv
// Pixel FIFO read port, framebuffer memory port and status outputs of the
// depth writer, bundled so the writer and its environment share one handle.
interface pixel_depth_writer_if #(
  parameter int unsigned ADDR_W = 20
);
  // FIFO read side
  logic [47:0]       fifo_q;
  logic              fifo_empty;
  logic              fifo_rdreq;
  // Mode
  logic              depth_test_en;
  // Framebuffer memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;
  // Status
  logic              busy;
  logic [15:0]       drawn_count;
  logic [15:0]       reject_count;

  // master: the depth writer itself (pops the FIFO, drives the memory port)
  modport master (
    input  fifo_q, fifo_empty, depth_test_en, mem_rdata, mem_ack,
    output fifo_rdreq, mem_req, mem_we, mem_addr, mem_wdata,
           busy, drawn_count, reject_count
  );

  // slave: the FIFO, memory and host surrounding the writer
  modport slave (
    output fifo_q, fifo_empty, depth_test_en, mem_rdata, mem_ack,
    input  fifo_rdreq, mem_req, mem_we, mem_addr, mem_wdata,
           busy, drawn_count, reject_count
  );
endinterface

// File: rtl/pixel_depth_writer.sv
// Drain stage behind the rasteriser pixel FIFO. Pops one packed pixel
// {x, y, z, color}, rejects off-screen pixels, optionally performs a z-buffer
// read/compare, then writes depth and colour to the shared framebuffer port.
// Every output comes straight from a register.
module pixel_depth_writer #(
  parameter int unsigned       SCREEN_W = 640,
  parameter int unsigned       SCREEN_H = 480,
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] Z_BASE   = 20'h00000,
  parameter logic [ADDR_W-1:0] C_BASE   = 20'h80000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  pixel_depth_writer_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_ZREAD  = 3'd2;
  localparam logic [2:0] S_ZCMP   = 3'd3;
  localparam logic [2:0] S_ZWRITE = 3'd4;
  localparam logic [2:0] S_CWRITE = 3'd5;

  logic [2:0]        r_state;
  logic              r_rdreq;
  logic              r_busy;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic [15:0]       r_drawn;
  logic [15:0]       r_reject;
  logic [ADDR_W-1:0] r_pix;
  logic [15:0]       r_z;
  logic [11:0]       r_color;
  logic [15:0]       r_zold;

  logic [2:0]        w_state_nxt;
  logic [9:0]        w_x;
  logic [9:0]        w_y;
  logic [15:0]       w_z;
  logic [11:0]       w_color;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_pix;
  logic              w_xfer_done;

  // Field split of the FIFO word; only meaningful in LATCH, one cycle after the pop
  assign w_x     = bus.fifo_q[47:38];
  assign w_y     = bus.fifo_q[37:28];
  assign w_z     = bus.fifo_q[27:12];
  assign w_color = bus.fifo_q[11:0];

  assign w_in_range = ({22'd0, w_x} < SCREEN_W) && ({22'd0, w_y} < SCREEN_H);
  // Linear pixel index, deliberately truncated to the memory address width
  assign w_pix = ADDR_W'(w_y) * ADDR_W'(SCREEN_W) + ADDR_W'(w_x);

  // An ack only counts while a request is actually outstanding
  assign w_xfer_done = r_mem_req & bus.mem_ack;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state selection for the pixel pipeline
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_rdreq) w_state_nxt = S_LATCH;
      S_LATCH: begin
        if (!w_in_range)           w_state_nxt = S_IDLE;
        else if (bus.depth_test_en) w_state_nxt = S_ZREAD;
        else                       w_state_nxt = S_ZWRITE;
      end
      S_ZREAD:  if (w_xfer_done) w_state_nxt = S_ZCMP;
      S_ZCMP:   w_state_nxt = (r_z < r_zold) ? S_ZWRITE : S_IDLE;
      S_ZWRITE: if (w_xfer_done) w_state_nxt = S_CWRITE;
      S_CWRITE: if (w_xfer_done) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State, FIFO pop, memory request registers, pixel latch and counters
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_rdreq     <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_drawn     <= '0;
      r_reject    <= '0;
      r_pix       <= '0;
      r_z         <= '0;
      r_color     <= '0;
      r_zold      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      // One-cycle pop pulse, raised from IDLE only; LATCH follows the pulse
      r_rdreq <= (r_state == S_IDLE) && !r_rdreq && !bus.fifo_empty;

      case (r_state)
        S_LATCH: begin
          r_pix   <= w_pix;
          r_z     <= w_z;
          r_color <= w_color;
          if (!w_in_range) begin
            r_reject <= sat_inc(r_reject);
          end else begin
            // Depth traffic starts on the very next cycle: read if testing, else write
            r_mem_req   <= 1'b1;
            r_mem_we    <= !bus.depth_test_en;
            r_mem_addr  <= Z_BASE + w_pix;
            r_mem_wdata <= w_z;
          end
        end
        S_ZREAD: begin
          if (w_xfer_done) begin
            r_mem_req <= 1'b0;
            r_zold    <= bus.mem_rdata;
          end
        end
        S_ZCMP: begin
          // Strictly nearer wins; equal depth is treated as occluded
          if (r_z < r_zold) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= Z_BASE + r_pix;
            r_mem_wdata <= r_z;
          end else begin
            r_reject <= sat_inc(r_reject);
          end
        end
        S_ZWRITE: begin
          if (w_xfer_done) r_mem_req <= 1'b0;
        end
        S_CWRITE: begin
          // Entered with mem_req low, which gives the idle gap after the depth write
          if (w_xfer_done) begin
            r_mem_req <= 1'b0;
            r_drawn   <= sat_inc(r_drawn);
          end else if (!r_mem_req) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= C_BASE + r_pix;
            r_mem_wdata <= {4'b0, r_color};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rdreq   = r_rdreq;
  assign bus.busy         = r_busy;
  assign bus.mem_req      = r_mem_req;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.drawn_count  = r_drawn;
  assign bus.reject_count = r_reject;

endmodule
